// File: rtl/kuz_pkg.sv
// rtl/kuz_pkg.sv - Kuznyechik constants, GF(2^8) helpers and sequencer state type
//
// Contents:
//   NR_DEF, L_STEPS_DEF  default round-key count and R-steps per L transform
//   GF_POLY              field polynomial x^8+x^7+x^6+x+1
//   state_t              sequencer FSM states
//   SBOX                 byte substitution table pi
//   L_COEF               l coefficients, index 0 multiplies a15, index 15 multiplies a0
//   gf_mul               GF(2^8) multiply
//   s_layer              16 parallel S-box lookups over a 128-bit block
package kuz_pkg;

  localparam int NR_DEF      = 10;
  localparam int L_STEPS_DEF = 16;

  localparam logic [8:0] GF_POLY = 9'h1C3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_XS   = 3'd1,
    S_LR   = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  localparam logic [7:0] L_COEF [0:15] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      // Multiply x by the generator; bit 8 of the polynomial is implied by the carry.
      x = x[7] ? ((x << 1) ^ GF_POLY[7:0]) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] s_layer(input logic [127:0] a);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = SBOX[a[8*i +: 8]];
    end
    return r;
  endfunction

endpackage

// File: rtl/kuz_r_step.sv
// rtl/kuz_r_step.sv - one Kuznyechik R step (linear feedback over 16 bytes)
//
// Ports:
//   blk  in   128  input block, byte a15 = [127:120], a0 = [7:0]
//   res  out  128  R(blk) = l(a15..a0) || a15..a1
import kuz_pkg::*;

module kuz_r_step (
  input  logic [127:0] blk,
  output logic [127:0] res
);

  logic [7:0] l;

  always_comb begin
    l = '0;
    for (int i = 0; i < 16; i++) begin
      l = l ^ gf_mul(blk[8*(15-i) +: 8], L_COEF[i]);
    end
    // New top byte is l; the block shifts down one byte, dropping a0.
    res = {l, blk[127:8]};
  end

endmodule

// File: rtl/kuz_round_ctrl.sv
// rtl/kuz_round_ctrl.sv - Kuznyechik single-block encryption sequencer
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   data_i     in   128  plaintext block
//   in_valid   in   1    data_i valid
//   in_ready   out  1    ready to accept a block (IDLE only)
//   data_o     out  128  ciphertext, stable while out_valid
//   out_valid  out  1    data_o valid
//   out_ready  in   1    consumer takes data_o
//   rk_idx     out  4    round-key index to the key store
//   rk_i       in   128  round key for rk_idx, combinational return
//   busy       out  1    block in flight or waiting to be taken
import kuz_pkg::*;

module kuz_round_ctrl #(
  parameter int NR      = NR_DEF,
  parameter int L_STEPS = L_STEPS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_i,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] data_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_i,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NR - 2);
  localparam logic [3:0] KEY_LAST   = 4'(NR - 1);
  localparam logic [3:0] STEP_LAST  = 4'(L_STEPS - 1);

  state_t       state;
  state_t       state_n;
  logic [127:0] st;
  logic [127:0] r_out;
  logic [3:0]   round;
  logic [3:0]   step;
  logic [3:0]   rk_hold;

  kuz_r_step u_r_step (
    .blk (st),
    .res (r_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (in_valid) state_n = S_XS;
      S_XS:   state_n = S_LR;
      // round still holds the pre-increment value on the last step.
      S_LR:   if (step == STEP_LAST) state_n = (round == LAST_ROUND) ? S_FIN : S_XS;
      S_FIN:  state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);
    rk_idx    = rk_hold;
    case (state)
      S_IDLE: in_ready  = 1'b1;
      S_XS:   rk_idx    = round;
      S_FIN:  rk_idx    = KEY_LAST;
      S_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign data_o = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= '0;
      round   <= '0;
      step    <= '0;
      rk_hold <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            st    <= data_i;
            round <= '0;
          end
        end
        S_XS: begin
          st      <= s_layer(st ^ rk_i);
          step    <= '0;
          rk_hold <= rk_idx;
        end
        S_LR: begin
          st   <= r_out;
          step <= step + 4'd1;
          if (step == STEP_LAST) round <= round + 4'd1;
        end
        S_FIN: begin
          st      <= st ^ rk_i;
          rk_hold <= rk_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
